inv_sub_bytes_seq: RTL

Sequential AES inverse SubBytes stage for the decryption datapath. It accepts a 128-bit state on a valid/ready handshake and substitutes every byte through the inverse S-box, a configurable number of columns per cycle. It then presents the result on a valid/ready output. It sits directly upstream of the inverse MixColumns stage and, with the fused AddRoundKey option, supplies that stage's input directly.

---
 rtl/inv_sub_bytes_seq.sv | 130 +++++++++++++
 1 files changed

// File: rtl/inv_sub_bytes_seq.sv
// rtl/inv_sub_bytes_seq.sv - AES inverse SubBytes, COLS_PER_CYCLE columns per cycle; optional fused AddRoundKey via FUSE_ARK_EN
module inv_sub_bytes_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic [127:0] round_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("inv_sub_bytes_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [2:0] COLS3    = 3'(COLS_PER_CYCLE);
    localparam logic [1:0] COLS2    = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_COL = 2'(4 - COLS_PER_CYCLE);

    // Row v of this constant holds InvSbox(16v .. 16v+15); value 0 sits in the top byte.
    localparam logic [2047:0] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_SBOX[{~b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [127:0]   r_in_buf;
    logic [127:0]   r_result;
    logic [1:0]     r_col_cnt;
    logic [127:0]   w_key;
    logic [127:0]   w_next_result;

`ifdef FUSE_ARK_EN
    logic [127:0]   r_key_buf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_key_buf <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_key_buf <= round_key;
        end
    end

    assign w_key = r_key_buf;
`else
    logic w_unused_key;

    assign w_unused_key = ^round_key;
    assign w_key        = '0;
`endif

    // A column belongs to this cycle's group when its offset from col_cnt is below COLS_PER_CYCLE.
    always_comb begin
        w_next_result = r_result;
        for (int c = 0; c < 4; c++) begin
            if ({1'b0, 2'(2'(c) - r_col_cnt)} < COLS3) begin
                for (int r = 0; r < 4; r++) begin
                    w_next_result[32*c + 8*r +: 8] = inv_sbox(r_in_buf[32*c + 8*r +: 8])
                                                   ^ w_key[32*c + 8*r +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_next_state = RUN;
            RUN:     if (r_col_cnt == LAST_COL) w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_in_buf  <= '0;
            r_result  <= '0;
            r_col_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_in_buf  <= state_in;
                        r_col_cnt <= '0;
                    end
                end
                RUN: begin
                    r_result  <= w_next_result;
                    r_col_cnt <= r_col_cnt + COLS2;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign state_out = r_result;

endmodule
